// File: rtl/memory_access_controller.sv
// ----------------------------------------------------------------------------
// memory_access_controller
//
// Single bus initiator for the synchronous main memory. Two requesters share
// it: an instruction-fetch port (read only) and a data port (load/store).
// The winner's address goes into MAR (mem_addr) and its store data into
// MBR (mem_wdata). The controller then issues one read or write cycle, waits
// out the memory's registered read latency and answers the owner with done.
//
// Handshake (both ports): four-phase req/done. The requester raises req with
// its address, write enable and data stable, and holds them until done rises.
// done stays high until req is seen low, then falls on that same edge. The
// controller is back in IDLE after that edge and samples requests on the next
// one. err is only meaningful while done is high. rdata is valid while done
// is high and holds its value until that port's next read completes.
//
// Ports
//   clk, reset           clock, asynchronous active-high reset
//   f_req/f_addr         fetch request and address
//   f_done/f_rdata/f_err fetch completion, fetched word, out-of-range flag
//   d_req/d_we/d_addr/d_wdata  data request, write enable, address, store data
//   d_done/d_rdata/d_err data completion, loaded word, out-of-range flag
//   mem_addr/mem_wdata/mem_we  memory bus (MAR, MBR, one-clock write strobe)
//   mem_rdata            memory read data (registered inside the memory)
//   busy                 high whenever the controller is not in IDLE
//   dbg_state            current FSM state (0 IDLE, 1 ISSUE, 2 WAIT, 3 RESP)
// ----------------------------------------------------------------------------
module memory_access_controller #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int MEM_DEPTH    = 16384,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_done,
    output logic [DATA_W-1:0] f_rdata,
    output logic              f_err,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    localparam int                CNT_W    = $clog2(READ_LATENCY + 1);
    // One extra bit so MEM_DEPTH == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0]   LP_DEPTH = (ADDR_W + 1)'(MEM_DEPTH);
    localparam logic [CNT_W-1:0]  LP_LAT   = CNT_W'(READ_LATENCY);
    localparam logic [CNT_W-1:0]  LP_ONE   = CNT_W'(1);

    state_t            r_state;
    logic              r_owner_d;   // 1: data port owns the transaction
    logic              r_we;
    logic [CNT_W-1:0]  r_lat_cnt;

    logic [ADDR_W-1:0] w_sel_addr;
    logic              w_sel_oor;
    logic              w_owner_req;

    // Fixed priority: the data port wins when both request together.
    assign w_sel_addr  = d_req ? d_addr : f_addr;
    assign w_sel_oor   = ({1'b0, w_sel_addr} >= LP_DEPTH);
    assign w_owner_req = r_owner_d ? d_req : f_req;
    assign dbg_state   = r_state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_owner_d <= 1'b0;
            r_we      <= 1'b0;
            r_lat_cnt <= '0;
            busy      <= 1'b0;
            f_done    <= 1'b0;
            f_err     <= 1'b0;
            f_rdata   <= '0;
            d_done    <= 1'b0;
            d_err     <= 1'b0;
            d_rdata   <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
        end else begin
            // Write strobe lives only for the single ISSUE clock.
            mem_we <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (d_req || f_req) begin
                        busy      <= 1'b1;
                        r_owner_d <= d_req;
                        r_we      <= d_req & d_we;
                        mem_addr  <= w_sel_addr;
                        if (d_req) begin
                            mem_wdata <= d_wdata;
                        end
                        if (w_sel_oor) begin
                            // No memory cycle at all; answer with err and a zero word.
                            r_state <= S_RESP;
                            if (d_req) begin
                                d_done  <= 1'b1;
                                d_err   <= 1'b1;
                                d_rdata <= '0;
                            end else begin
                                f_done  <= 1'b1;
                                f_err   <= 1'b1;
                                f_rdata <= '0;
                            end
                        end else begin
                            r_state <= S_ISSUE;
                            mem_we  <= d_req & d_we;
                        end
                    end
                end
                S_ISSUE: begin
                    if (r_we) begin
                        // Only the data port can write.
                        r_state <= S_RESP;
                        d_done  <= 1'b1;
                    end else begin
                        r_lat_cnt <= LP_LAT;
                        r_state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_lat_cnt == LP_ONE) begin
                        r_state <= S_RESP;
                        if (r_owner_d) begin
                            d_rdata <= mem_rdata;
                            d_done  <= 1'b1;
                        end else begin
                            f_rdata <= mem_rdata;
                            f_done  <= 1'b1;
                        end
                    end else begin
                        r_lat_cnt <= r_lat_cnt - LP_ONE;
                    end
                end
                S_RESP: begin
                    // The non-owner's req is ignored here; it is served from IDLE.
                    if (!w_owner_req) begin
                        r_state <= S_IDLE;
                        busy    <= 1'b0;
                        f_done  <= 1'b0;
                        f_err   <= 1'b0;
                        d_done  <= 1'b0;
                        d_err   <= 1'b0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_access_controller.sv
module tb_memory_access_controller;

    localparam int AW    = 16;
    localparam int DW    = 16;
    localparam int DEPTH = 16384;
    localparam int RL    = 1;
    localparam int RL3   = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // shared request-side inputs; each DUT has its own req lines
    logic          f_req, d_req, f_req3, d_req3, d_we;
    logic [AW-1:0] f_addr, d_addr;
    logic [DW-1:0] d_wdata;

    // DUT (READ_LATENCY = 1)
    logic          f_done, f_err, d_done, d_err, mem_we, busy;
    logic [DW-1:0] f_rdata, d_rdata, mem_wdata, mem_rdata;
    logic [AW-1:0] mem_addr;
    logic [1:0]    dbg_state;

    // DUT (READ_LATENCY = 3)
    logic          f_done3, f_err3, d_done3, d_err3, mem_we3, busy3;
    logic [DW-1:0] f_rdata3, d_rdata3, mem_wdata3, mem_rdata3;
    logic [AW-1:0] mem_addr3;
    logic [1:0]    dbg_state3;

    memory_access_controller #(.ADDR_W(AW), .DATA_W(DW), .MEM_DEPTH(DEPTH), .READ_LATENCY(RL)) dut (
        .clk(clk), .reset(reset),
        .f_req(f_req), .f_addr(f_addr), .f_done(f_done), .f_rdata(f_rdata), .f_err(f_err),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata), .d_err(d_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
        .busy(busy), .dbg_state(dbg_state)
    );

    memory_access_controller #(.ADDR_W(AW), .DATA_W(DW), .MEM_DEPTH(DEPTH), .READ_LATENCY(RL3)) dut3 (
        .clk(clk), .reset(reset),
        .f_req(f_req3), .f_addr(f_addr), .f_done(f_done3), .f_rdata(f_rdata3), .f_err(f_err3),
        .d_req(d_req3), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done3), .d_rdata(d_rdata3), .d_err(d_err3),
        .mem_addr(mem_addr3), .mem_wdata(mem_wdata3), .mem_we(mem_we3), .mem_rdata(mem_rdata3),
        .busy(busy3), .dbg_state(dbg_state3)
    );

    // ---------------- memory models ----------------
    logic [DW-1:0] mem1 [0:DEPTH-1];
    logic [DW-1:0] mem3 [0:DEPTH-1];
    logic [DW-1:0] rd1;
    logic [DW-1:0] p0, p1, p2;

    always @(posedge clk) begin
        if (mem_we) mem1[mem_addr[13:0]] <= mem_wdata;
        rd1 <= mem1[mem_addr[13:0]];
    end
    assign mem_rdata = rd1;

    always @(posedge clk) begin
        if (mem_we3) mem3[mem_addr3[13:0]] <= mem_wdata3;
        p0 <= mem3[mem_addr3[13:0]];
        p1 <= p0;
        p2 <= p1;
    end
    assign mem_rdata3 = p2;

    // ---------------- scoreboard state ----------------
    int            vectors = 0;
    int            miscompares = 0;
    logic [DW-1:0] ref_mem [0:DEPTH-1];
    logic [DW-1:0] exp_f_rdata, exp_d_rdata;
    int            we_count = 0;
    logic [AW-1:0] last_we_addr;
    logic [DW-1:0] last_we_data;

    // Counts clocks with the write strobe high, sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_we) begin
            we_count     <= we_count + 1;
            last_we_addr <= mem_addr;
            last_we_data <= mem_wdata;
        end
    end

    // ---------------- generic access driver ----------------
    task automatic do_access(input bit is_d, input bit we, input logic [AW-1:0] addr,
                             input logic [DW-1:0] wdata);
        int edges;
        int exp_edges;
        int we_before;
        bit got;
        bit other_bad;
        bit exp_err;
        logic [DW-1:0] exp_rd;
        exp_err   = (int'(addr) >= DEPTH);
        exp_edges = exp_err ? 1 : (we ? 2 : 2 + RL);
        we_before = we_count;
        @(posedge clk); #1;
        if (is_d) begin
            d_we = we; d_addr = addr; d_wdata = wdata; d_req = 1'b1;
        end else begin
            f_addr = addr; f_req = 1'b1;
        end
        edges = 0; got = 0; other_bad = 0;
        while (!got && edges < 20) begin
            @(posedge clk); #1;
            edges++;
            if (is_d ? d_done : f_done) got = 1;
            if (is_d ? f_done : d_done) other_bad = 1;
        end
        vectors++;
        if (!got || edges != exp_edges) begin
            miscompares++;
            $display("FAIL access_latency addr=%h we=%0b: done=%0b after %0d edges, want done after %0d", addr, we, got, edges, exp_edges);
        end
        if (exp_err) exp_rd = '0;
        else if (we) exp_rd = exp_d_rdata;
        else exp_rd = ref_mem[addr];
        if (is_d) exp_d_rdata = exp_rd; else exp_f_rdata = exp_rd;
        vectors++;
        if ((is_d ? d_rdata : f_rdata) !== exp_rd) begin
            miscompares++;
            $display("FAIL access_rdata addr=%h port_d=%0b: got %h want %h", addr, is_d, is_d ? d_rdata : f_rdata, exp_rd);
        end
        vectors++;
        if ((is_d ? d_err : f_err) !== exp_err) begin
            miscompares++;
            $display("FAIL access_err addr=%h: got %b want %b", addr, is_d ? d_err : f_err, exp_err);
        end
        vectors++;
        if (other_bad !== 1'b0) begin
            miscompares++;
            $display("FAIL other_port_done: other done seen=%b want 0", other_bad);
        end
        vectors++;
        if ((is_d ? f_rdata : d_rdata) !== (is_d ? exp_f_rdata : exp_d_rdata)) begin
            miscompares++;
            $display("FAIL other_rdata_hold: got %h want %h", is_d ? f_rdata : d_rdata, is_d ? exp_f_rdata : exp_d_rdata);
        end
        vectors++;
        if ((we_count - we_before) != ((we && !exp_err) ? 1 : 0)) begin
            miscompares++;
            $display("FAIL mem_we_cycles addr=%h: got %0d want %0d", addr, we_count - we_before, (we && !exp_err) ? 1 : 0);
        end
        if (we && !exp_err) begin
            vectors++;
            if ({last_we_addr, last_we_data} !== {addr, wdata}) begin
                miscompares++;
                $display("FAIL mem_write_bus: got %h/%h want %h/%h", last_we_addr, last_we_data, addr, wdata);
            end
            ref_mem[addr] = wdata;
        end
        if (is_d) d_req = 1'b0; else f_req = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if ({f_done, d_done, busy} !== 3'b000) begin
            miscompares++;
            $display("FAIL release: {f_done,d_done,busy} got %b want 000", {f_done, d_done, busy});
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        f_req = 0; d_req = 0; f_req3 = 0; d_req3 = 0; d_we = 0;
        f_addr = '0; d_addr = '0; d_wdata = '0;
        for (int i = 0; i < DEPTH; i++) begin
            mem1[i] <= '0;
            mem3[i] <= '0;
            ref_mem[i] = '0;
        end
        exp_f_rdata = '0; exp_d_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({busy, f_done, d_done, f_err, d_err, mem_we} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got %b want 000000", {busy, f_done, d_done, f_err, d_err, mem_we});
        end
        vectors++;
        if ({f_rdata, d_rdata, mem_addr, mem_wdata} !== '0) begin
            miscompares++;
            $display("FAIL reset_buses: f_rdata=%h d_rdata=%h mem_addr=%h mem_wdata=%h want all 0", f_rdata, d_rdata, mem_addr, mem_wdata);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if (busy !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_after_reset: busy got %b want 0", busy);
        end
    endtask

    task automatic test_write_read();
        do_access(1'b1, 1'b1, 16'h0010, 16'h1234);
        do_access(1'b1, 1'b0, 16'h0010, 16'h0000);
        do_access(1'b0, 1'b0, 16'h0010, 16'h0000);
    endtask

    task automatic test_priority();
        int edges;
        bit got;
        bit f_bad;
        do_access(1'b1, 1'b1, 16'h0020, 16'hA5C3);
        do_access(1'b1, 1'b1, 16'h0011, 16'h3C5A);
        @(posedge clk); #1;
        f_addr = 16'h0011; f_req = 1'b1;
        d_we = 1'b0; d_addr = 16'h0020; d_req = 1'b1;
        edges = 0; got = 0; f_bad = 0;
        while (!got && edges < 20) begin
            @(posedge clk); #1;
            edges++;
            if (d_done) got = 1;
            if (f_done) f_bad = 1;
        end
        vectors++;
        if (!got || edges != 2 + RL || d_rdata !== ref_mem[16'h0020]) begin
            miscompares++;
            $display("FAIL prio_data_first: done=%0b edges=%0d rdata=%h want done at %0d rdata=%h", got, edges, d_rdata, 2 + RL, ref_mem[16'h0020]);
        end
        exp_d_rdata = ref_mem[16'h0020];
        d_req = 1'b0;
        edges = 0; got = 0;
        while (!got && edges < 20) begin
            @(posedge clk); #1;
            edges++;
            if (f_done) got = 1;
            if (d_done && edges > 1) f_bad = 1;
        end
        vectors++;
        if (f_bad !== 1'b0) begin
            miscompares++;
            $display("FAIL prio_fetch_waits: early/overlapping done seen=%b want 0", f_bad);
        end
        vectors++;
        if (!got || edges != 3 + RL || f_rdata !== ref_mem[16'h0011] || f_err !== 1'b0 || d_rdata !== exp_d_rdata) begin
            miscompares++;
            $display("FAIL prio_fetch_done: done=%0b edges=%0d f_rdata=%h f_err=%b d_rdata=%h want edges %0d f_rdata=%h", got, edges, f_rdata, f_err, d_rdata, 3 + RL, ref_mem[16'h0011]);
        end
        exp_f_rdata = ref_mem[16'h0011];
        f_req = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if ({f_done, busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL prio_release: {f_done,busy} got %b want 00", {f_done, busy});
        end
    endtask

    task automatic test_out_of_range();
        do_access(1'b1, 1'b1, 16'h4000, 16'hDEAD);
        do_access(1'b1, 1'b0, 16'h0000, 16'h0000);
        do_access(1'b0, 1'b0, 16'hFFFF, 16'h0000);
        do_access(1'b1, 1'b0, 16'h3FFF, 16'h0000);
    endtask

    task automatic test_hold();
        int edges;
        int we_before;
        bit got;
        bit bad;
        @(posedge clk); #1;
        d_we = 1'b1; d_addr = 16'h0012; d_wdata = 16'h7E81; d_req = 1'b1;
        edges = 0; got = 0; bad = 0;
        while (!got && edges < 20) begin
            @(posedge clk); #1;
            edges++;
            if (d_done) got = 1;
        end
        ref_mem[16'h0012] = 16'h7E81;
        we_before = we_count;
        repeat (5) begin
            @(posedge clk); #1;
            if (!d_done || !busy) bad = 1;
        end
        vectors++;
        if (!got || bad) begin
            miscompares++;
            $display("FAIL hold_done: done=%0b dropped_during_hold=%0b want 1/0", got, bad);
        end
        vectors++;
        if (we_count != we_before) begin
            miscompares++;
            $display("FAIL hold_no_reaccess: extra mem_we cycles %0d want 0", we_count - we_before);
        end
        d_req = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if ({d_done, busy} !== 2'b00) begin
            miscompares++;
            $display("FAIL hold_release: {d_done,busy} got %b want 00", {d_done, busy});
        end
    endtask

    task automatic test_latency3();
        int edges;
        bit got;
        mem3[5] <= 16'hBEEF;
        @(posedge clk); #1;
        d_we = 1'b0; d_addr = 16'h0005; d_req3 = 1'b1;
        edges = 0; got = 0;
        while (!got && edges < 20) begin
            @(posedge clk); #1;
            edges++;
            if (d_done3) got = 1;
        end
        vectors++;
        if (!got || edges != 2 + RL3) begin
            miscompares++;
            $display("FAIL lat3_timing: done=%0b after %0d edges want %0d", got, edges, 2 + RL3);
        end
        vectors++;
        if (d_rdata3 !== 16'hBEEF || d_err3 !== 1'b0) begin
            miscompares++;
            $display("FAIL lat3_data: got %h err=%b want BEEF err=0", d_rdata3, d_err3);
        end
        d_req3 = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if ({d_done3, busy3} !== 2'b00) begin
            miscompares++;
            $display("FAIL lat3_release: got %b want 00", {d_done3, busy3});
        end
    endtask

    task automatic test_random();
        bit            is_d;
        bit            we;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        for (int n = 0; n < 40; n++) begin
            is_d = 1'($urandom_range(0, 1));
            we   = is_d ? 1'($urandom_range(0, 1)) : 1'b0;
            if ($urandom_range(0, 7) == 0) addr = 16'($urandom_range(DEPTH, 65535));
            else addr = 16'($urandom_range(0, 31));
            data = 16'($urandom);
            do_access(is_d, we, addr, data);
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        d_we = 1'b1; d_addr = 16'h0030; d_wdata = 16'h5555; d_req = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (mem_we !== 1'b1 || mem_addr !== 16'h0030) begin
            miscompares++;
            $display("FAIL rst_mid_issue: mem_we=%b mem_addr=%h want 1/0030", mem_we, mem_addr);
        end
        reset = 1'b1;
        #1;
        vectors++;
        if ({mem_we, busy, d_done, d_rdata, f_rdata} !== '0) begin
            miscompares++;
            $display("FAIL rst_mid_clear: mem_we=%b busy=%b d_done=%b d_rdata=%h f_rdata=%h want all 0", mem_we, busy, d_done, d_rdata, f_rdata);
        end
        exp_d_rdata = '0; exp_f_rdata = '0;
        d_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if ({busy, d_done} !== 2'b00) begin
            miscompares++;
            $display("FAIL rst_mid_idle: {busy,d_done} got %b want 00", {busy, d_done});
        end
        do_access(1'b1, 1'b0, 16'h0010, 16'h0000);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_write_read();
        test_priority();
        test_out_of_range();
        test_hold();
        test_latency3();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/memory_access_controller.md
# memory_access_controller

Bus initiator that drives the synchronous main memory on behalf of the CPU: it owns the MAR/MBR path, arbitrates between an instruction-fetch port and a data (load/store) port, issues single-word read or write cycles, waits out the memory's registered read latency and returns data through a four-phase req/done handshake. It sits between the control FSM and the main memory, so the memory only ever sees one requester.

## Interface
- ADDR_W, 16, address width of ports and memory bus
- DATA_W, 16, data word width
- MEM_DEPTH, 16384, number of implemented words; addresses >= MEM_DEPTH are errors
- READ_LATENCY, 1, clocks from the issue edge to valid mem_rdata (>= 1)

- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state and outputs immediately
- f_req  in  1  fetch request (level; held with f_addr stable until f_done)
- f_addr  in  ADDR_W  fetch address
- f_done  out  1  fetch complete; held high until f_req falls
- f_rdata  out  DATA_W  fetched word, valid while f_done high, held until next fetch completes
- f_err  out  1  fetch address out of range, qualified by f_done
- d_req  in  1  data request (level; d_we/d_addr/d_wdata stable until d_done)
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_done  out  1  data access complete; held high until d_req falls
- d_rdata  out  DATA_W  loaded word, valid while d_done high, held until next data read completes
- d_err  out  1  data address out of range, qualified by d_done
- mem_addr  out  ADDR_W  memory address (MAR)
- mem_wdata  out  DATA_W  memory write data (MBR)
- mem_we  out  1  memory write enable, high exactly one clock per write
- mem_rdata  in  DATA_W  memory read data (registered inside memory)
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, ISSUE, WAIT, RESP. All outputs registered.
- IDLE: sample f_req/d_req at each edge. Both high -> data port wins (fixed priority; fetch waits). Winner's addr -> MAR, wdata -> MBR, we and owner latched.
- Range check in IDLE: addr >= MEM_DEPTH -> go straight to RESP with err=1, rdata unchanged-to-0 (rdata forced 0), mem_we never asserted.
- ISSUE: mem_addr=MAR, mem_we=we (mem_wdata=MBR). Write -> RESP next edge. Read -> WAIT, latency counter loaded with READ_LATENCY.
- WAIT: counter decrements each edge; at count 1 capture mem_rdata into the owner's rdata register and go to RESP.
- RESP: owner's done=1 (other port's done stays 0), err as computed. Remain until owner's req samples low, then done=0 and return to IDLE. Non-owner req ignored in RESP.
- mem_we is 0 in every state except ISSUE-for-write; mem_addr holds last MAR value between transactions.
- Reset values: state IDLE, busy 0, all done/err 0, f_rdata/d_rdata 0, mem_addr 0, mem_wdata 0, mem_we 0, latency counter 0.

## Timing
- Edge E0: req sampled in IDLE. ISSUE during E0..E1; memory acts on E1.
- Write: done high after E1 (2 edges from request).
- Read: data captured on E(1+READ_LATENCY), done high after it (READ_LATENCY=1 -> done after E2).
- Out-of-range: done/err high after E0 (1 edge).
- Handshake: done falls on the first edge that sees owner req low; controller is in IDLE after that edge and samples requests on the following edge (one dead cycle between transactions).
- Requester changing addr/data while req high is illegal; latched copies are used, so no glitch reaches memory.
- Reset asserted mid-transaction: outputs clear immediately (mem_we drops combinationally from the async clear); an in-flight write may or may not have landed; no done is produced for the aborted access.
- Reset deasserted with req high: request is serviced as new from IDLE.

## Test plan
- Data write 0x1234 to 0x0010, then data read 0x0010 -> mem_we high exactly one cycle with mem_addr 0x0010; read d_done after 2nd edge, d_rdata=0x1234, d_err=0.
- f_req and d_req (read 0x0020) raised same cycle -> data served first, f_done stays 0; after d_req drops, fetch completes with correct f_rdata.
- d_req write to 0x4000 (MEM_DEPTH 16384) -> d_done and d_err after 1 edge, mem_we never asserted, memory contents unchanged.
- Hold d_req high 5 cycles after d_done -> d_done stays high, busy stays high, no second memory access; drop req -> done low next edge, IDLE.
- READ_LATENCY=3 build: read 0x0005 holding 0xBEEF -> d_done rises after 4th edge, d_rdata=0xBEEF.
- Assert reset during ISSUE of a write -> mem_we, busy, done cleared same cycle; after release, state IDLE and next read completes normally.
